// File: rtl/reg_file_2w2r.sv
// Two-write, two-read register file with registered reads, optional write-to-read
// forwarding, optional hardwired-zero entry 0, and a built-in clear sequencer that
// zeroes every entry after reset or on request.
module reg_file_2w2r #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          REG0_ZERO = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned     DEPTH   = 2 ** ADDR_W;
    // One spare bit on the pointer so the terminal compare never aliases with a wrap.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        stateQ, stateD;
    logic [ADDR_W:0]   cptrQ, cptrD;
    logic              writeOk;
    logic              commit0, commit1;
    logic [DATA_W-1:0] rdNext1, rdNext2;

    // A clear request takes priority over the writes presented on the same edge.
    assign writeOk = (stateQ == StIdle) && !clr_req;
    assign commit0 = writeOk && we0 && !(REG0_ZERO && (waddr0 == '0));
    assign commit1 = writeOk && we1 && !(REG0_ZERO && (waddr1 == '0));

    assign ready = (stateQ == StIdle);

    // Clear sequencer: IDLE waits for a request, CLEAR walks cptr over every entry.
    always_comb begin
        stateD = stateQ;
        cptrD  = cptrQ;
        case (stateQ)
            StIdle: begin
                if (clr_req) begin
                    stateD = StClear;
                    cptrD  = '0;
                end
            end
            StClear: begin
                if (cptrQ == LastIdx) begin
                    stateD = StIdle;
                    cptrD  = '0;
                end else begin
                    cptrD = cptrQ + PtrOne;
                end
            end
            default: begin
                stateD = StClear;
                cptrD  = '0;
            end
        endcase
    end

    // Sequencer state; reset restarts the clear from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StClear;
            cptrQ  <= '0;
        end else begin
            stateQ <= stateD;
            cptrQ  <= cptrD;
        end
    end

    // Storage array: cleared one entry per edge, else written with port 1 winning a tie.
    always_ff @(posedge clk) begin
        if (stateQ == StClear) begin
            mem[cptrQ[ADDR_W-1:0]] <= '0;
        end else begin
            if (commit0) mem[waddr0] <= wdata0;
            if (commit1) mem[waddr1] <= wdata1;
        end
    end

    // Read-side next values, with forwarding of same-edge writes when enabled.
    always_comb begin
        rdNext1 = mem[raddr1];
        rdNext2 = mem[raddr2];
        if (BYPASS) begin
            if (commit0 && (waddr0 == raddr1)) rdNext1 = wdata0;
            if (commit1 && (waddr1 == raddr1)) rdNext1 = wdata1;
            if (commit0 && (waddr0 == raddr2)) rdNext2 = wdata0;
            if (commit1 && (waddr1 == raddr2)) rdNext2 = wdata1;
        end
        if (REG0_ZERO && (raddr1 == '0)) rdNext1 = '0;
        if (REG0_ZERO && (raddr2 == '0)) rdNext2 = '0;
        if (stateQ == StClear) begin
            rdNext1 = '0;
            rdNext2 = '0;
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            rdata1 <= rdNext1;
            rdata2 <= rdNext2;
        end
    end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: a forwarding instance and a non-forwarding instance share
// all stimulus and are compared each edge against an array-based reference model.
module tb_reg_file_2w2r;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clrReq = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [4:0] waddr0 = '0, waddr1 = '0, raddr1 = '0, raddr2 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic       ready, readyNb;
    logic [7:0] rdata1, rdata2, rdata1Nb, rdata2Nb;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] model [32];
    int         clearLeft = 32;
    logic [7:0] exp1, exp2, exp1Nb, exp2Nb;

    always #5 clk = ~clk;

    reg_file_2w2r #(.DATA_W(8), .ADDR_W(5), .REG0_ZERO(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .clr_req(clrReq), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
    );

    reg_file_2w2r #(.DATA_W(8), .ADDR_W(5), .REG0_ZERO(1'b1), .BYPASS(1'b0)) dutNb (
        .clk(clk), .rst(rst), .clr_req(clrReq), .ready(readyNb),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1Nb), .rdata2(rdata2Nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic setIdle();
        clrReq = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic randomInputs();
        we0 = 1'($urandom); we1 = 1'($urandom);
        waddr0 = 5'($urandom); waddr1 = 5'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        raddr1 = 5'($urandom); raddr2 = 5'($urandom);
        // Bias some reads onto the write addresses to exercise forwarding.
        if ($urandom_range(0, 3) == 0) raddr1 = waddr0;
        if ($urandom_range(0, 3) == 0) raddr2 = waddr1;
    endtask

    // Advance one edge: update the model from the current inputs, then compare.
    task automatic step();
        logic [7:0] nxt [32];
        if (clearLeft > 0) begin
            model[32 - clearLeft] = '0;
            clearLeft--;
            exp1 = '0; exp2 = '0; exp1Nb = '0; exp2Nb = '0;
        end else if (clrReq) begin
            clearLeft = 32;
            exp1 = (raddr1 == 0) ? 8'h00 : model[raddr1];
            exp2 = (raddr2 == 0) ? 8'h00 : model[raddr2];
            exp1Nb = exp1;
            exp2Nb = exp2;
        end else begin
            nxt = model;
            if (we0 && waddr0 != 0) nxt[waddr0] = wdata0;
            if (we1 && waddr1 != 0) nxt[waddr1] = wdata1;
            exp1   = (raddr1 == 0) ? 8'h00 : nxt[raddr1];
            exp2   = (raddr2 == 0) ? 8'h00 : nxt[raddr2];
            exp1Nb = (raddr1 == 0) ? 8'h00 : model[raddr1];
            exp2Nb = (raddr2 == 0) ? 8'h00 : model[raddr2];
            model = nxt;
        end
        @(posedge clk);
        #1;
        check("rdata1", {24'b0, rdata1}, {24'b0, exp1});
        check("rdata2", {24'b0, rdata2}, {24'b0, exp2});
        check("rdata1_nobypass", {24'b0, rdata1Nb}, {24'b0, exp1Nb});
        check("rdata2_nobypass", {24'b0, rdata2Nb}, {24'b0, exp2Nb});
        check("ready", {31'b0, ready}, (clearLeft == 0) ? 32'd1 : 32'd0);
        check("ready_nobypass", {31'b0, readyNb}, (clearLeft == 0) ? 32'd1 : 32'd0);
    endtask

    // Assert reset between edges, check the asynchronous effect, release after one edge.
    task automatic doReset();
        rst = 1'b1;
        clearLeft = 32;
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rdata1", {24'b0, rdata1}, 32'd0);
        check("reset_rdata2", {24'b0, rdata2}, 32'd0);
        check("reset_ready_nobypass", {31'b0, readyNb}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Step until ready rises (bounded) and check the number of clear edges.
    task automatic countClear(input string tag, input bit rnd);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            if (rnd) begin
                randomInputs();
                clrReq = 1'($urandom);
            end
            step();
            n++;
        end
        check(tag, n, 32);
        setIdle();
    endtask

    task automatic readAll();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            step();
            check("readall_rdata1", {24'b0, rdata1}, 32'd0);
        end
        setIdle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Power-up reset and initial clear.
        #2;
        doReset();
        countClear("reset_clear_edges", 1'b0);
        readAll();

        // Write then read on both read ports.
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 8'h09;
        step();
        setIdle();
        raddr1 = 5'd1; raddr2 = 5'd1;
        step();
        check("wr_rd1_addr1", {24'b0, rdata1}, 32'h09);
        check("wr_rd2_addr1", {24'b0, rdata2}, 32'h09);

        // Same-address collision: port 1 wins.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 8'hAA;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 8'h55;
        step();
        setIdle();
        raddr1 = 5'd3;
        step();
        check("collision_addr3", {24'b0, rdata1}, 32'h55);

        // Forwarding vs. pre-write value.
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 8'h11;
        step();
        wdata0 = 8'h7E; raddr1 = 5'd4;
        step();
        check("bypass_on", {24'b0, rdata1}, 32'h7E);
        check("bypass_off", {24'b0, rdata1Nb}, 32'h11);
        setIdle();

        // Hardwired zero entry, including same-edge forwarding onto address 0.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 8'hFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 8'hFF;
        step();
        setIdle();
        step();
        check("reg0_zero", {24'b0, rdata1}, 32'h00);

        // Clear mid-operation; the request edge itself drops its writes.
        for (int a = 5; a <= 8; a++) begin
            we0 = 1'b1; waddr0 = 5'(a); wdata0 = 8'(8'hC0 + a);
            step();
        end
        setIdle();
        clrReq = 1'b1; we0 = 1'b1; waddr0 = 5'd9; wdata0 = 8'h99;
        step();
        check("clr_req_ready_low", {31'b0, ready}, 32'd0);
        setIdle();
        countClear("clr_req_clear_edges", 1'b1);
        for (int a = 5; a <= 9; a++) begin
            raddr1 = 5'(a);
            step();
            check("after_clear", {24'b0, rdata1}, 32'h00);
        end
        setIdle();

        // Reset ten edges into a clear restarts it from entry 0.
        for (int a = 20; a <= 23; a++) begin
            we1 = 1'b1; waddr1 = 5'(a); wdata1 = 8'(8'h30 + a);
            step();
        end
        setIdle();
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        repeat (10) step();
        doReset();
        countClear("restart_clear_edges", 1'b0);
        readAll();

        // Randomized traffic with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            randomInputs();
            clrReq = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
